// File: rtl/macro_sel_ctrl.sv
// User-macro slot controller: picks one of N_MACROS macros and switches between
// them break-before-make (isolate, disable, guard, enable, guard, release).
module macro_sel_ctrl #(
    parameter int N_MACROS     = 4,
    parameter int SEL_W        = 2,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic                la_req_i,
    input  logic [SEL_W-1:0]    la_sel_i,
    output logic [N_MACROS-1:0] macro_en_o,
    output logic [SEL_W-1:0]    macro_sel_o,
    output logic                io_isolate_o,
    output logic                busy_o,
    output logic                irq_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        DISABLE = 3'd2,
        ENABLE  = 3'd3,
        ACTIVE  = 3'd4
    } state_t;

    typedef struct packed {
        logic             en;
        logic [SEL_W-1:0] sel;
    } req_t;

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] N_LIM    = 8'(N_MACROS);

    state_t           state_q, state_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic             en_q, en_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    req_t             tgt_q, tgt_d, pend_q, eff, new_req;
    logic             pend_v_q, eff_v;
    logic             done_q, err_q, ack_q, la_q;
    logic [31:0]      dat_q, rdata;
    logic [8:0]       ctrl_q;

    logic       wb_acc, wb_ctrl_wr, wb_flag_wr, la_edge;
    logic       req_v, req_en, req_bad, req_ok;
    logic [7:0] req_sel8;
    logic       busy, done_set;
    logic       unused_ok;

    assign unused_ok  = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:9]};

    assign wb_acc     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wb_ctrl_wr = wb_acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign wb_flag_wr = wb_acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd2);
    assign la_edge    = la_req_i & ~la_q;
    assign busy       = (state_q == ISOLATE) || (state_q == DISABLE) || (state_q == ENABLE);

    // A CTRL write in the same cycle as an LA edge shadows the LA request.
    always_comb begin
        req_v    = wb_ctrl_wr | la_edge;
        req_en   = wb_ctrl_wr ? wbs_dat_i[8]   : 1'b1;
        req_sel8 = wb_ctrl_wr ? wbs_dat_i[7:0] : 8'(la_sel_i);
        req_bad  = req_v & req_en & (req_sel8 >= N_LIM);
        req_ok   = req_v & ~req_bad;
        new_req  = '{en: req_en, sel: req_sel8[SEL_W-1:0]};
        eff_v    = req_ok | pend_v_q;
        eff      = req_ok ? new_req : pend_q;
    end

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        en_d      = en_q;
        cur_sel_d = cur_sel_q;
        tgt_d     = tgt_q;
        done_set  = 1'b0;
        case (state_q)
            IDLE: if (eff_v && eff.en) begin
                tgt_d   = eff;
                state_d = ISOLATE;
            end
            ACTIVE: if (eff_v && (eff != {1'b1, cur_sel_q})) begin
                tgt_d   = eff;
                state_d = ISOLATE;
            end
            ISOLATE: begin
                state_d = DISABLE;
                en_d    = 1'b0;
                gcnt_d  = GUARD_LD;
            end
            DISABLE: if (gcnt_q == 8'd0) begin
                if (tgt_q.en) begin
                    state_d   = ENABLE;
                    cur_sel_d = tgt_q.sel;
                    en_d      = 1'b1;
                    gcnt_d    = GUARD_LD;
                end else begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end else begin
                gcnt_d = gcnt_q - 8'd1;
            end
            ENABLE: if (gcnt_q == 8'd0) begin
                state_d  = ACTIVE;
                done_set = 1'b1;
            end else begin
                gcnt_d = gcnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:2])
            2'd0: rdata[8:0] = ctrl_q;
            2'd1: begin
                rdata[SEL_W-1:0] = cur_sel_q;
                rdata[8]         = en_q;
                rdata[9]         = busy;
                rdata[12:10]     = state_q;
                rdata[13]        = pend_v_q;
            end
            2'd2: rdata[1:0] = {err_q, done_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            gcnt_q    <= '0;
            en_q      <= 1'b0;
            cur_sel_q <= '0;
            tgt_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ctrl_q    <= '0;
            la_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            en_q      <= en_d;
            cur_sel_q <= cur_sel_d;
            tgt_q     <= tgt_d;
            la_q      <= la_req_i;
            ack_q     <= wb_acc;
            dat_q     <= (wb_acc && !wbs_we_i) ? rdata : '0;
            if (wb_ctrl_wr) ctrl_q <= wbs_dat_i[8:0];
            // Single-deep pending slot; drained whenever the FSM is at rest.
            if (busy && req_ok) begin
                pend_q   <= new_req;
                pend_v_q <= 1'b1;
            end else if (!busy) begin
                pend_v_q <= 1'b0;
            end
            done_q <= done_set | (done_q & ~(wb_flag_wr & wbs_dat_i[0]));
            err_q  <= req_bad  | (err_q  & ~(wb_flag_wr & wbs_dat_i[1]));
        end
    end

    always_comb begin
        macro_en_o = '0;
        if (en_q) macro_en_o = {{(N_MACROS-1){1'b0}}, 1'b1} << cur_sel_q;
    end

    assign macro_sel_o  = cur_sel_q;
    assign io_isolate_o = (state_q != ACTIVE);
    assign busy_o       = busy;
    assign irq_o        = done_q | err_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
endmodule

// File: tb/tb_macro_sel_ctrl.sv
// Directed bench for macro_sel_ctrl: timed sequence tables plus hand-written
// corner cases (reject, WB/LA collision, pending, reset mid-sequence).
module tb_macro_sel_ctrl;
    logic        clk, rst_n;
    logic        stb, cyc, we;
    logic [3:0]  bsel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat;
    logic        la_req;
    logic [1:0]  la_sel;
    logic [3:0]  en;
    logic [1:0]  sel;
    logic        iso, busy, irq;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int base;
    logic [31:0] rd;

    typedef struct {
        int         c;
        logic [3:0] en;
        logic [1:0] sel;
        logic       iso;
        logic       busy;
    } seq_vec_t;

    seq_vec_t seq2 [6];
    seq_vec_t seq3 [6];

    macro_sel_ctrl #(.N_MACROS(4), .SEL_W(2), .GUARD_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(bsel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .la_req_i(la_req), .la_sel_i(la_sel),
        .macro_en_o(en), .macro_sel_o(sel), .io_isolate_o(iso),
        .busy_o(busy), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The enable vector must never be two-hot.
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if (!$onehot0(en)) begin
                n_fail++;
                $display("FAIL en_onehot0: got %b required at most one bit set", en);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic step_to(input int c);
        while (cyc_cnt - base < c) step();
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r);
        int n = 0;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; bsel = 4'hf;
        step();
        while (!ack && n < 4) begin
            step();
            n++;
        end
        chk("wb_ack", {31'b0, ack}, 32'h1);
        r = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic run_seq(input string name, input seq_vec_t v[6]);
        for (int i = 0; i < 6; i++) begin
            step_to(v[i].c);
            chk({name, "_en"},   {28'b0, en},   {28'b0, v[i].en});
            chk({name, "_sel"},  {30'b0, sel},  {30'b0, v[i].sel});
            chk({name, "_iso"},  {31'b0, iso},  {31'b0, v[i].iso});
            chk({name, "_busy"}, {31'b0, busy}, {31'b0, v[i].busy});
        end
    endtask

    initial begin
        seq2[0] = '{1,  4'b0000, 2'd0, 1'b1, 1'b1};
        seq2[1] = '{2,  4'b0000, 2'd0, 1'b1, 1'b1};
        seq2[2] = '{9,  4'b0000, 2'd0, 1'b1, 1'b1};
        seq2[3] = '{10, 4'b0010, 2'd1, 1'b1, 1'b1};
        seq2[4] = '{17, 4'b0010, 2'd1, 1'b1, 1'b1};
        seq2[5] = '{18, 4'b0010, 2'd1, 1'b0, 1'b0};
        seq3[0] = '{1,  4'b0010, 2'd1, 1'b1, 1'b1};
        seq3[1] = '{2,  4'b0000, 2'd1, 1'b1, 1'b1};
        seq3[2] = '{9,  4'b0000, 2'd1, 1'b1, 1'b1};
        seq3[3] = '{10, 4'b1000, 2'd3, 1'b1, 1'b1};
        seq3[4] = '{17, 4'b1000, 2'd3, 1'b1, 1'b1};
        seq3[5] = '{18, 4'b1000, 2'd3, 1'b0, 1'b0};

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; bsel = 4'h0;
        wdat = '0; adr = '0; la_req = 1'b0; la_sel = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: reset state
        chk("rst_en", {28'b0, en}, 32'h0);
        chk("rst_iso", {31'b0, iso}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_sel", {30'b0, sel}, 32'h0);
        wb(1'b0, 32'h4, 32'h0, rd);
        chk("rst_stat", rd, 32'h0);
        step();

        // 2: CTRL write selects macro 1 from IDLE
        wb(1'b1, 32'h0, 32'h101, rd);
        base = cyc_cnt - 1;
        run_seq("seq2", seq2);
        chk("seq2_irq", {31'b0, irq}, 32'h1);
        wb(1'b0, 32'h8, 32'h0, rd);
        chk("seq2_flag", rd, 32'h1);
        wb(1'b0, 32'h4, 32'h0, rd);
        chk("seq2_stat", rd, 32'h1101);
        wb(1'b0, 32'h0, 32'h0, rd);
        chk("seq2_ctrl", rd, 32'h101);
        wb(1'b1, 32'h8, 32'h1, rd);
        chk("w1c_done_irq", {31'b0, irq}, 32'h0);

        // 3: LA edge switches macro 1 -> 3
        la_sel = 2'd3; la_req = 1'b1;
        base = cyc_cnt;
        run_seq("seq3", seq3);
        la_req = 1'b0;
        wb(1'b1, 32'h8, 32'h1, rd);

        // 4: out-of-range request is rejected
        wb(1'b1, 32'h0, 32'h106, rd);
        repeat (2) step();
        chk("rej_en", {28'b0, en}, 32'h8);
        chk("rej_sel", {30'b0, sel}, 32'h3);
        chk("rej_iso", {31'b0, iso}, 32'h0);
        chk("rej_busy", {31'b0, busy}, 32'h0);
        chk("rej_irq", {31'b0, irq}, 32'h1);
        wb(1'b0, 32'h8, 32'h0, rd);
        chk("rej_flag", rd, 32'h2);
        wb(1'b1, 32'h8, 32'h2, rd);
        chk("w1c_err_irq", {31'b0, irq}, 32'h0);
        repeat (2) step();

        // 4b: same-cycle WB sel2 and LA sel3, WB wins
        la_sel = 2'd3; la_req = 1'b1;
        wb(1'b1, 32'h0, 32'h102, rd);
        base = cyc_cnt - 1;
        step_to(17);
        chk("coll_busy17", {31'b0, busy}, 32'h1);
        step_to(18);
        chk("coll_sel", {30'b0, sel}, 32'h2);
        chk("coll_en", {28'b0, en}, 32'h4);
        chk("coll_iso", {31'b0, iso}, 32'h0);
        la_req = 1'b0;
        step_to(24);
        chk("coll_sel_late", {30'b0, sel}, 32'h2);
        wb(1'b1, 32'h8, 32'h1, rd);
        repeat (2) step();

        // 5: pending requests during DISABLE, last one wins
        wb(1'b1, 32'h0, 32'h100, rd);
        base = cyc_cnt - 1;
        step_to(3);
        wb(1'b1, 32'h0, 32'h102, rd);
        wb(1'b1, 32'h0, 32'h103, rd);
        wb(1'b0, 32'h4, 32'h0, rd);
        chk("pend_stat", rd, 32'h2A02);
        step_to(18);
        chk("pend_mid_sel", {30'b0, sel}, 32'h0);
        chk("pend_mid_en", {28'b0, en}, 32'h1);
        chk("pend_mid_iso", {31'b0, iso}, 32'h0);
        step_to(19);
        chk("pend_take_busy", {31'b0, busy}, 32'h1);
        chk("pend_take_en", {28'b0, en}, 32'h1);
        step_to(36);
        chk("pend_final_sel", {30'b0, sel}, 32'h3);
        chk("pend_final_en", {28'b0, en}, 32'h8);
        chk("pend_final_iso", {31'b0, iso}, 32'h0);

        // 5b: async reset in ENABLE with a pending request
        wb(1'b1, 32'h0, 32'h101, rd);
        base = cyc_cnt - 1;
        step_to(11);
        wb(1'b1, 32'h0, 32'h102, rd);
        chk("enable_en", {28'b0, en}, 32'h2);
        chk("enable_busy", {31'b0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", {28'b0, en}, 32'h0);
        chk("arst_sel", {30'b0, sel}, 32'h0);
        chk("arst_iso", {31'b0, iso}, 32'h1);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        chk("arst_ack", {31'b0, ack}, 32'h0);
        chk("arst_dat", rdat, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("post_rst_en", {28'b0, en}, 32'h0);
        chk("post_rst_iso", {31'b0, iso}, 32'h1);
        wb(1'b0, 32'h4, 32'h0, rd);
        chk("post_rst_stat", rd, 32'h0);
        wb(1'b0, 32'h8, 32'h0, rd);
        chk("post_rst_flag", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
